// File: rtl/alu_multicycle.sv
// alu_multicycle: ALU with single-cycle arithmetic/logic, bit-serial shifts and
// an optional iterative signed multiplier.
// Build option: define ALU_MUL_EN to include the shift-add multiplier for opcode
// 111; without it that opcode returns zero in a single cycle.
module alu_multicycle #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opc,
  input  logic [WIDTH-1:0] inN,
  input  logic [WIDTH-1:0] inM,
  input  logic             inC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outF,
  output logic             zer,
  output logic             neg,
  output logic             ovf,
  output logic             cout
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned SW  = WIDTH + 1;
`ifdef ALU_MUL_EN
  localparam int unsigned PW  = 2 * WIDTH;
`endif

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       op_q, op_n;
  logic [WIDTH-1:0] sreg_q, sreg_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             busy_n, done_n;
  logic [WIDTH-1:0] outf_n;
  logic             zer_n, neg_n, ovf_n, cout_n;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] addb;
  logic             add_cin;
  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] one_res;
  logic             one_ovf, one_cout;
  logic [WIDTH-1:0] shift_res;

  logic             fin;
  logic [WIDTH-1:0] fin_res;
  logic             fin_ovf, fin_cout;

`ifdef ALU_MUL_EN
  logic [PW-1:0]    acc_q, acc_n, mcand_q, mcand_n, addend, prod;
  logic [WIDTH-1:0] mplier_q, mplier_n;
`endif

  // Single-cycle results computed straight from the request inputs
  always_comb begin
    sh       = inM[SHW-1:0];
    addb     = (opc == OP_SUB) ? ~inM : inM;
    add_cin  = (opc == OP_SUB) ? 1'b1 : inC;
    sum      = {1'b0, inN} + {1'b0, addb} + SW'(add_cin);
    one_res  = '0;
    one_ovf  = 1'b0;
    one_cout = 1'b0;
    case (opc)
      OP_ADD, OP_SUB: begin
        one_res  = sum[WIDTH-1:0];
        one_cout = sum[WIDTH];
        one_ovf  = (inN[WIDTH-1] == addb[WIDTH-1]) && (sum[WIDTH-1] != inN[WIDTH-1]);
      end
      OP_AND:         one_res = inN & inM;
      OP_OR:          one_res = inN | inM;
      OP_NOT:         one_res = ~inM;
      OP_ASR, OP_SHL: one_res = inN;  // zero shift amount
      default:        one_res = '0;   // multiply opcode with no multiplier built
    endcase
  end

  // One iteration of the running shift or multiply
  always_comb begin
    shift_res = (op_q == OP_ASR) ? {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]}
                                 : {sreg_q[WIDTH-2:0], 1'b0};
`ifdef ALU_MUL_EN
    // The multiplier MSB carries negative weight, so the final step subtracts
    addend = '0;
    if (mplier_q[0]) begin
      addend = (cnt_q == CW'(1)) ? (~mcand_q + PW'(1)) : mcand_q;
    end
    prod = acc_q + addend;
`endif
  end

  // Next state, datapath update and result/flag capture
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    sreg_n   = sreg_q;
    cnt_n    = cnt_q;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    outf_n   = outF;
    zer_n    = zer;
    neg_n    = neg;
    ovf_n    = ovf;
    cout_n   = cout;
    fin      = 1'b0;
    fin_res  = '0;
    fin_ovf  = 1'b0;
    fin_cout = 1'b0;
`ifdef ALU_MUL_EN
    acc_n    = acc_q;
    mcand_n  = mcand_q;
    mplier_n = mplier_q;
`endif
    case (state)
      RUN: begin
        busy_n = 1'b1;
        cnt_n  = cnt_q - CW'(1);
        sreg_n = shift_res;
`ifdef ALU_MUL_EN
        acc_n    = prod;
        mcand_n  = {mcand_q[PW-2:0], 1'b0};
        mplier_n = {1'b0, mplier_q[WIDTH-1:1]};
`endif
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          fin_res = shift_res;
`ifdef ALU_MUL_EN
          if (op_q == OP_MUL) begin
            fin_res = prod[WIDTH-1:0];
            fin_ovf = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
          end
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        state_n = IDLE;
        if (start) begin
          op_n = opc;
          if ((opc == OP_ASR || opc == OP_SHL) && sh != '0) begin
            state_n = RUN;
            busy_n  = 1'b1;
            sreg_n  = inN;
            cnt_n   = CW'(sh);
          end
`ifdef ALU_MUL_EN
          else if (opc == OP_MUL) begin
            state_n  = RUN;
            busy_n   = 1'b1;
            acc_n    = '0;
            mcand_n  = {{WIDTH{inN[WIDTH-1]}}, inN};
            mplier_n = inM;
            cnt_n    = CW'(WIDTH);
          end
`endif
          else begin
            fin      = 1'b1;
            fin_res  = one_res;
            fin_ovf  = one_ovf;
            fin_cout = one_cout;
          end
        end
      end
    endcase
    if (fin) begin
      state_n = DONE;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      outf_n  = fin_res;
      zer_n   = (fin_res == '0);
      neg_n   = fin_res[WIDTH-1];
      ovf_n   = fin_ovf;
      cout_n  = fin_cout;
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_ADD;
      sreg_q   <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      outF     <= '0;
      zer      <= 1'b1;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      cout     <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      sreg_q   <= sreg_n;
      cnt_q    <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      outF     <= outf_n;
      zer      <= zer_n;
      neg      <= neg_n;
      ovf      <= ovf_n;
      cout     <= cout_n;
`ifdef ALU_MUL_EN
      acc_q    <= acc_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: random and directed stimulus against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int unsigned W = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic         clk, rst, start;
  logic [2:0]   opc;
  logic [W-1:0] inN, inM;
  logic         inC;
  logic         busy, done;
  logic [W-1:0] outF;
  logic         zer, neg, ovf, cout;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] last_res;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opc(opc),
    .inN(inN), .inM(inM), .inC(inC),
    .busy(busy), .done(done), .outF(outF),
    .zer(zer), .neg(neg), .ovf(ovf), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the signed/unsigned operand values
  function automatic void model(input logic [2:0] op, input logic [W-1:0] n, input logic [W-1:0] m,
                                input logic c, output logic [W-1:0] res, output logic o,
                                output logic co, output int lat);
    longint sn, sm, un, um, t, u;
    int sh;
    sn = $signed(n);
    sm = $signed(m);
    un = n;
    um = m;
    sh = int'(m[3:0]);
    res = '0; o = 1'b0; co = 1'b0; lat = 1; t = 0; u = 0;
    case (op)
      OP_ADD: begin t = sn + sm + longint'(c); u = un + um + longint'(c); end
      OP_SUB: begin t = sn - sm; u = un + (65535 - um) + 1; end
      OP_ASR: begin res = W'(sn >>> sh); lat = sh + 1; end
      OP_SHL: begin res = W'(un << sh); lat = sh + 1; end
      OP_AND: res = n & m;
      OP_OR:  res = n | m;
      OP_NOT: res = ~m;
      default: begin
`ifdef ALU_MUL_EN
        t   = sn * sm;
        res = W'(t);
        o   = (t > 32767) || (t < -32768);
        lat = 17;
`endif
      end
    endcase
    if (op == OP_ADD || op == OP_SUB) begin
      res = W'(u);
      co  = u[16];
      o   = (t > 32767) || (t < -32768);
    end
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [4];
    edges = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  // Issue one request, scramble inputs while busy, optionally poke start mid-run
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] n, input logic [W-1:0] m,
                        input logic c, input int poke, input bit b2b);
    logic [W-1:0] eres, prev;
    logic         eo, eco;
    int           elat, lat_obs;
    model(op, n, m, c, eres, eo, eco, elat);
    if (!b2b) begin
      @(negedge clk);
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_hold", outF, last_res);
    end
    prev  = last_res;
    start = 1'b1; opc = op; inN = n; inM = m; inC = c;
    lat_obs = 41;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done) begin
        lat_obs = j;
        break;
      end
      chk("busy", busy, 1'b1);
      chk("hold", outF, prev);
      start = (j == poke);
      opc = 3'($urandom); inN = W'($urandom); inM = W'($urandom); inC = 1'($urandom);
    end
    start = 1'b0;
    chk("latency", lat_obs, elat);
    chk("busy_at_done", busy, 1'b0);
    chk("outF", outF, eres);
    chk("zer", zer, eres == '0);
    chk("neg", neg, eres[W-1]);
    chk("ovf", ovf, eo);
    chk("cout", cout, eco);
    last_res = eres;
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] rn, rm;
    rst = 1'b1; start = 1'b0; opc = '0; inN = '0; inM = '0; inC = 1'b0;
    last_res = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_outF", outF, 16'h0000);
    chk("rst_zer", zer, 1'b1);
    chk("rst_neg", neg, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_cout", cout, 1'b0);
    rst = 1'b0;

    run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    chk("add_max_out", outF, 16'h8000);
    chk("add_max_ovf", ovf, 1'b1);
    run_op(OP_SUB, 16'h0005, 16'h0005, 1'b0, 0, 1'b0);
    chk("sub_eq_zer", zer, 1'b1);
    chk("sub_eq_cout", cout, 1'b1);
    run_op(OP_ASR, 16'h8000, 16'h0003, 1'b0, 2, 1'b0);
    chk("asr_out", outF, 16'hF000);
    run_op(OP_MUL, 16'hFFFD, 16'h0007, 1'b0, 3, 1'b0);
`ifdef ALU_MUL_EN
    chk("mul_out", outF, 16'hFFEB);
`else
    chk("mul_off_out", outF, 16'h0000);
`endif
    run_op(OP_AND, 16'h0F0F, 16'h00FF, 1'b0, 0, 1'b0);
    chk("and_out", outF, 16'h000F);
    run_op(OP_OR, 16'h0F00, 16'h00F0, 1'b0, 0, 1'b1);
    chk("or_b2b_out", outF, 16'h0FF0);
    run_op(OP_SHL, 16'h1234, 16'h0010, 1'b0, 0, 1'b1);
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 0, 1'b0);
    run_op(OP_NOT, 16'h0000, 16'h5A5A, 1'b0, 0, 1'b1);
    run_op(OP_SHL, 16'h0001, 16'h000F, 1'b0, 5, 1'b0);

    // Reset in the middle of a long operation
    run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, 0, 1'b0);
    @(negedge clk);
    start = 1'b1;
`ifdef ALU_MUL_EN
    opc = OP_MUL; inN = 16'hFFFD; inM = 16'h0007;
`else
    opc = OP_ASR; inN = 16'h8000; inM = 16'h000F;
`endif
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j <= 5) chk("abort_pre_busy", busy, 1'b1);
      if (j == 6) begin
        chk("abort_busy", busy, 1'b0);
        chk("abort_outF", outF, 16'h0000);
        chk("abort_zer", zer, 1'b1);
      end
      chk("abort_no_done", done, 1'b0);
      rst = (j == 5);
    end
    last_res = '0;

    // Reset wins over a simultaneous request
    run_op(OP_ADD, 16'h0001, 16'h0002, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; opc = OP_ADD; inN = 16'h0003; inM = 16'h0004; inC = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rs_done", done, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_outF", outF, 16'h0000);
    @(negedge clk);
    chk("rs_done2", done, 1'b0);
    last_res = '0;

    for (int i = 0; i < 250; i++) begin
      rop = 3'($urandom);
      rn  = pick();
      rm  = pick();
      run_op(rop, rn, rm, 1'($urandom), int'($urandom_range(0, 20)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
